sram_ctrl: RTL and testbench

SRAM_CTRL -- requirements
Module: sram_ctrl

---
 rtl/mem_pkg.sv | 17 +
 rtl/sram_array.sv | 28 ++
 rtl/sram_ctrl.sv | 171 +++++++++++++++++
 tb/tb_sram_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the SRAM controller: legal parameter ranges and the response payload.
package mem_pkg;

  localparam int unsigned READ_LAT_MIN  = 1;
  localparam int unsigned READ_LAT_MAX  = 3;
  localparam int unsigned RSP_DEPTH_MIN = 1;
  localparam int unsigned RSP_DEPTH_MAX = 4;

  // Widest memory word a controller instance may use; responses carry data zero-extended to this.
  localparam int unsigned RSP_DATA_MAX  = 256;

  typedef struct packed {
    logic [RSP_DATA_MAX-1:0] rdata;
    logic                    rerr;
  } rsp_t;

endpackage

// File: rtl/sram_array.sv
// Single-port SRAM with byte write enables and a one-cycle registered read port.
module sram_array #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 1024,
  localparam int unsigned ADDR_W = $clog2(DEPTH),
  localparam int unsigned WB     = DATA_W / 8
) (
  input  logic              clock,
  input  logic              en,
  input  logic [WB-1:0]     we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Byte-masked write and read of the pre-write contents on every enabled cycle.
  always_ff @(posedge clock) begin
    if (en) begin
      for (int b = 0; b < int'(WB); b++) begin
        if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/sram_ctrl.sv
// Request/response front end for sram_array: credit-based grant, fixed read latency, in-order response FIFO.
module sram_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned READ_LAT  = 1,
  parameter int unsigned RSP_DEPTH = 2,
  localparam int unsigned ADDR_W = $clog2(DEPTH),
  localparam int unsigned WB     = DATA_W / 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  output logic              gnt,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WB-1:0]     we,
  input  logic [DATA_W-1:0] wdata,
  output logic              rvalid,
  input  logic              rready,
  output logic [DATA_W-1:0] rdata,
  output logic              rerr
);

  localparam int unsigned CW  = 3;
  localparam int unsigned AW1 = ADDR_W + 1;
  localparam int unsigned PW  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned FQ  = 1 << PW;

  // Parameter legality, checked at elaboration.
  if (READ_LAT < READ_LAT_MIN || READ_LAT > READ_LAT_MAX) begin : g_bad_lat
    $error("sram_ctrl: READ_LAT out of range");
  end
  if (RSP_DEPTH < RSP_DEPTH_MIN || RSP_DEPTH > RSP_DEPTH_MAX) begin : g_bad_depth
    $error("sram_ctrl: RSP_DEPTH out of range");
  end
  if (DATA_W == 0 || (DATA_W % 8) != 0 || DATA_W > RSP_DATA_MAX) begin : g_bad_width
    $error("sram_ctrl: DATA_W must be a non-zero multiple of 8 within RSP_DATA_MAX");
  end
  if (DEPTH < 2) begin : g_bad_words
    $error("sram_ctrl: DEPTH must be at least 2");
  end

  logic [CW-1:0]     cnt;
  logic              accept;
  logic              in_range;
  logic              is_wr;
  logic              arr_en;
  logic [DATA_W-1:0] arr_rdata;
  logic              s1_v;
  logic              s1_err;
  logic              s1_wr;
  rsp_t              s1_rsp;
  logic              fin_v;
  rsp_t              fin_rsp;
  rsp_t              head;
  rsp_t              fq [FQ];
  logic [PW-1:0]     wp;
  logic [PW-1:0]     rp;
  logic [CW-1:0]     fcnt;
  logic              f_empty;
  logic              push;
  logic              pop;
  logic              fpop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Grant only while a response slot is guaranteed; depends on registered count alone.
  assign gnt      = cnt < CW'(RSP_DEPTH);
  assign accept   = req && gnt;
  assign in_range = {1'b0, addr} < AW1'(DEPTH);
  assign is_wr    = |we;
  assign arr_en   = accept && in_range && reset;

  sram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clock (clock),
    .en    (arr_en),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (arr_rdata)
  );

  // Outstanding-request counter: accepted but not yet consumed.
  always_ff @(posedge clock) begin
    if (!reset) cnt <= '0;
    else        cnt <= cnt + CW'(accept) - CW'(pop);
  end

  // First pipeline stage runs alongside the array read.
  always_ff @(posedge clock) begin
    if (!reset) begin
      s1_v   <= 1'b0;
      s1_err <= 1'b0;
      s1_wr  <= 1'b0;
    end else begin
      s1_v   <= accept;
      s1_err <= !in_range;
      s1_wr  <= is_wr;
    end
  end

  // Writes and out-of-range accesses respond with zero data.
  always_comb begin
    s1_rsp      = '0;
    s1_rsp.rerr = s1_err;
    if (!s1_err && !s1_wr) s1_rsp.rdata = RSP_DATA_MAX'(arr_rdata);
  end

  if (READ_LAT > 1) begin : g_tail
    localparam int unsigned TB = (READ_LAT - 1) * $bits(rsp_t);
    logic [READ_LAT-2:0] tl_v;
    rsp_t [READ_LAT-2:0] tl_rsp;

    // Extra latency stages: valid bits.
    always_ff @(posedge clock) begin
      if (!reset) tl_v <= '0;
      else        tl_v <= (READ_LAT-1)'({tl_v, s1_v});
    end

    // Extra latency stages: payload.
    always_ff @(posedge clock) begin
      tl_rsp <= TB'({tl_rsp, s1_rsp});
    end

    assign fin_v   = tl_v[READ_LAT-2];
    assign fin_rsp = tl_rsp[READ_LAT-2];
  end else begin : g_notail
    assign fin_v   = s1_v;
    assign fin_rsp = s1_rsp;
  end

  // A completed response bypasses the FIFO only when it is empty and the consumer is ready.
  assign f_empty = (fcnt == '0);
  assign rvalid  = !f_empty || fin_v;
  assign pop     = rvalid && rready;
  assign push    = fin_v && !(f_empty && rready);
  assign fpop    = pop && !f_empty;
  assign head    = f_empty ? fin_rsp : fq[rp];
  assign rdata   = rvalid ? head.rdata[DATA_W-1:0] : '0;
  assign rerr    = rvalid && head.rerr;

  if (DATA_W < RSP_DATA_MAX) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^head.rdata[RSP_DATA_MAX-1:DATA_W];
  end

  // Response FIFO pointers and occupancy.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wp   <= '0;
      rp   <= '0;
      fcnt <= '0;
    end else begin
      if (push) wp <= ptr_inc(wp);
      if (fpop) rp <= ptr_inc(rp);
      fcnt <= fcnt + CW'(push) - CW'(fpop);
    end
  end

  // Response FIFO storage.
  always_ff @(posedge clock) begin
    if (push) fq[wp] <= fin_rsp;
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: one instance at READ_LAT=1/DEPTH=1000, one streaming at READ_LAT=2.
module tb_sram_ctrl;

  bit          clock;

  logic        a_reset, a_req, a_gnt, a_rvalid, a_rready, a_rerr;
  logic [9:0]  a_addr;
  logic [3:0]  a_we;
  logic [31:0] a_wdata, a_rdata;

  logic        b_reset, b_req, b_gnt, b_rvalid, b_rready, b_rerr;
  logic [5:0]  b_addr;
  logic [3:0]  b_we;
  logic [31:0] b_wdata, b_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  sram_ctrl #(.DATA_W(32), .DEPTH(1000), .READ_LAT(1), .RSP_DEPTH(2)) u_a (
    .clock (clock), .reset (a_reset), .req (a_req), .gnt (a_gnt), .addr (a_addr),
    .we (a_we), .wdata (a_wdata), .rvalid (a_rvalid), .rready (a_rready),
    .rdata (a_rdata), .rerr (a_rerr)
  );

  sram_ctrl #(.DATA_W(32), .DEPTH(64), .READ_LAT(2), .RSP_DEPTH(3)) u_b (
    .clock (clock), .reset (b_reset), .req (b_req), .gnt (b_gnt), .addr (b_addr),
    .we (b_we), .wdata (b_wdata), .rvalid (b_rvalid), .rready (b_rready),
    .rdata (b_rdata), .rerr (b_rerr)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  initial begin
    // Reset held three cycles with requests pending
    a_reset = 0; a_req = 1; a_addr = 10'd5; a_we = 4'hF; a_wdata = 32'hDEADBEEF; a_rready = 1;
    b_reset = 0; b_req = 1; b_addr = 6'd0;  b_we = 4'h0; b_wdata = 32'h0;        b_rready = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_a_gnt", 64'(a_gnt), 64'd1);
      chk("rst_a_rvalid", 64'(a_rvalid), 64'd0);
      chk("rst_b_gnt", 64'(b_gnt), 64'd1);
      chk("rst_b_rvalid", 64'(b_rvalid), 64'd0);
    end
    a_reset = 1; a_req = 0; a_we = 4'h0;
    b_reset = 1; b_req = 0;
    step();
    chk("idle_rvalid", 64'(a_rvalid), 64'd0);
    chk("idle_rdata", 64'(a_rdata), 64'd0);
    chk("idle_rerr", 64'(a_rerr), 64'd0);

    // Byte-masked writes then read-after-write on the same word
    a_req = 1; a_addr = 10'd5; a_we = 4'hF; a_wdata = 32'hAABBCCDD;
    chk("bw_gnt", 64'(a_gnt), 64'd1);
    step();
    chk("bw_w1_rvalid", 64'(a_rvalid), 64'd1);
    chk("bw_w1_rdata", 64'(a_rdata), 64'd0);
    chk("bw_w1_rerr", 64'(a_rerr), 64'd0);
    a_we = 4'b0101; a_wdata = 32'h11223344;
    step();
    chk("bw_w2_rvalid", 64'(a_rvalid), 64'd1);
    chk("bw_w2_rdata", 64'(a_rdata), 64'd0);
    a_we = 4'h0;
    step();
    chk("bw_rd_rvalid", 64'(a_rvalid), 64'd1);
    chk("bw_rd_rdata", 64'(a_rdata), 64'hAA22CC44);
    chk("bw_rd_rerr", 64'(a_rerr), 64'd0);
    a_req = 0;
    step();
    chk("bw_done_rvalid", 64'(a_rvalid), 64'd0);

    // Back-pressure: two accepts, then grant drops until the first pop
    a_rready = 0; a_req = 1; a_addr = 10'd5; a_we = 4'h0;
    chk("bp_gnt0", 64'(a_gnt), 64'd1);
    step();
    chk("bp_gnt1", 64'(a_gnt), 64'd1);
    chk("bp_rdata1", 64'(a_rdata), 64'hAA22CC44);
    a_addr = 10'd1000;
    step();
    chk("bp_gnt2", 64'(a_gnt), 64'd0);
    chk("bp_rvalid2", 64'(a_rvalid), 64'd1);
    chk("bp_rdata2", 64'(a_rdata), 64'hAA22CC44);
    chk("bp_rerr2", 64'(a_rerr), 64'd0);
    step();
    chk("bp_gnt3", 64'(a_gnt), 64'd0);
    chk("bp_rdata3", 64'(a_rdata), 64'hAA22CC44);
    a_rready = 1;
    step();
    chk("bp_gnt4", 64'(a_gnt), 64'd1);
    chk("bp_rvalid4", 64'(a_rvalid), 64'd1);
    chk("bp_rdata4", 64'(a_rdata), 64'd0);
    chk("bp_rerr4", 64'(a_rerr), 64'd1);
    a_req = 0;
    step();
    chk("bp_empty", 64'(a_rvalid), 64'd0);

    // Out-of-range read and write leave memory alone
    a_req = 1; a_addr = 10'd999; a_we = 4'hF; a_wdata = 32'h99999999;
    step();
    chk("oor_w_rerr", 64'(a_rerr), 64'd0);
    a_addr = 10'd1000; a_we = 4'h0;
    step();
    chk("oor_rd_rvalid", 64'(a_rvalid), 64'd1);
    chk("oor_rd_rerr", 64'(a_rerr), 64'd1);
    chk("oor_rd_rdata", 64'(a_rdata), 64'd0);
    a_addr = 10'd1023; a_we = 4'hF; a_wdata = 32'hFFFFFFFF;
    step();
    chk("oor_wr_rerr", 64'(a_rerr), 64'd1);
    chk("oor_wr_rdata", 64'(a_rdata), 64'd0);
    a_addr = 10'd999; a_we = 4'h0;
    step();
    chk("oor_999_rdata", 64'(a_rdata), 64'h99999999);
    chk("oor_999_rerr", 64'(a_rerr), 64'd0);
    a_req = 0;
    step();
    chk("oor_empty", 64'(a_rvalid), 64'd0);

    // Reset with a write pending must not touch memory
    a_reset = 0; a_req = 1; a_addr = 10'd5; a_we = 4'hF; a_wdata = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rh_gnt", 64'(a_gnt), 64'd1);
      chk("rh_rvalid", 64'(a_rvalid), 64'd0);
    end
    a_reset = 1; a_we = 4'h0;
    step();
    chk("rh_rd_rvalid", 64'(a_rvalid), 64'd1);
    chk("rh_rd_rdata", 64'(a_rdata), 64'hAA22CC44);
    a_req = 0;
    step();

    // Streaming at READ_LAT=2: preload index values, then 16 back-to-back reads
    for (int i = 0; i < 16; i++) begin
      b_req = 1; b_addr = 6'(i); b_we = 4'hF; b_wdata = 32'(i);
      step();
    end
    b_req = 0; b_we = 4'h0;
    step(); step(); step();
    chk("st_drained", 64'(b_rvalid), 64'd0);
    for (int j = 0; j < 18; j++) begin
      if (j >= 2) begin
        chk("st_rvalid", 64'(b_rvalid), 64'd1);
        chk("st_rdata", 64'(b_rdata), 64'(j - 2));
      end else begin
        chk("st_latency", 64'(b_rvalid), 64'd0);
      end
      if (j < 16) begin
        b_req = 1; b_addr = 6'(j);
        chk("st_gnt", 64'(b_gnt), 64'd1);
      end else begin
        b_req = 0;
      end
      step();
    end
    chk("st_end", 64'(b_rvalid), 64'd0);

    // Reset with two reads in flight discards both responses
    b_rready = 0; b_req = 1; b_addr = 6'd7;
    step();
    b_addr = 6'd8;
    step();
    chk("mf_rvalid", 64'(b_rvalid), 64'd1);
    chk("mf_rdata", 64'(b_rdata), 64'd7);
    b_req = 0; b_reset = 0;
    step();
    b_reset = 1;
    chk("mf_gnt", 64'(b_gnt), 64'd1);
    chk("mf_rvalid0", 64'(b_rvalid), 64'd0);
    chk("mf_rdata0", 64'(b_rdata), 64'd0);
    step();
    chk("mf_rvalid1", 64'(b_rvalid), 64'd0);
    step();
    chk("mf_rvalid2", 64'(b_rvalid), 64'd0);
    b_rready = 1; b_req = 1; b_addr = 6'd9;
    step();
    b_req = 0;
    chk("mf_new_lat", 64'(b_rvalid), 64'd0);
    step();
    chk("mf_new_rvalid", 64'(b_rvalid), 64'd1);
    chk("mf_new_rdata", 64'(b_rdata), 64'd9);
    step();
    chk("mf_new_done", 64'(b_rvalid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
